// File: rtl/axis_endian_swap_slice_if.sv
// AXI4-Stream bundle (tdata/tkeep/tuser/tvalid/tready/tlast) with master/slave views.
interface axis_endian_swap_slice_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_endian_swap_slice.sv
// Registered AXI4-Stream endianness converter: reverses swap units across tdata/tkeep,
// per-packet swap enable, 2-entry skid buffer, and a count of accepted packets.
module axis_endian_swap_slice #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_SWAP_UNIT_BYTES  = 1,
  parameter int unsigned C_PKT_CNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        swap_en,
  axis_endian_swap_slice_if.slave     s_axis,
  axis_endian_swap_slice_if.master    m_axis,
  output logic [C_PKT_CNT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned KW = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UB = C_SWAP_UNIT_BYTES * 8;
  localparam int unsigned NU = C_AXIS_DATA_WIDTH / UB;
  localparam logic [C_PKT_CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  data;
    logic [KW-1:0]                 keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] user;
    logic                          last;
  } beat_t;

  typedef enum logic {SOP, IN_PKT} state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   beat_mode;

  beat_t  in_beat;
  beat_t  out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;
  logic   s_hs, out_ready;
  logic [C_PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign s_hs      = s_axis.tvalid & ready_q;
  assign out_ready = ~out_valid_q | m_axis.tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SOP;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (s_hs) begin
      if (state_q == SOP) mode_d = swap_en;
      state_d = s_axis.tlast ? SOP : IN_PKT;
    end
  end

  // First beat of a packet uses swap_en live; the rest use the latched mode.
  always_comb begin
    beat_mode = (state_q == SOP) ? swap_en : mode_q;
  end

  always_comb begin
    in_beat.data = s_axis.tdata;
    in_beat.keep = s_axis.tkeep;
    in_beat.user = s_axis.tuser;
    in_beat.last = s_axis.tlast;
    if (beat_mode) begin
      for (int unsigned k = 0; k < NU; k++) begin
        in_beat.data[k*UB +: UB] = s_axis.tdata[(NU-1-k)*UB +: UB];
        in_beat.keep[k*C_SWAP_UNIT_BYTES +: C_SWAP_UNIT_BYTES] =
          s_axis.tkeep[(NU-1-k)*C_SWAP_UNIT_BYTES +: C_SWAP_UNIT_BYTES];
      end
    end
  end

  // Skid holds a beat only while the output is stalled; tready is its registered inverse,
  // so an input beat and a pending skid beat never compete for the output register.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_hs;
        if (s_hs) out_d = in_beat;
      end
    end else if (s_hs) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
    cnt_d   = (s_hs & s_axis.tlast) ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign m_axis.tdata  = out_q.data;
  assign m_axis.tkeep  = out_q.keep;
  assign m_axis.tuser  = out_q.user;
  assign m_axis.tlast  = out_q.last;
  assign m_axis.tvalid = out_valid_q;
  assign s_axis.tready = ready_q;
  assign pkt_count     = cnt_q;

endmodule
